serial_add_sequencer: RTL and testbench

//  Bit-serial add controller: adds two WIDTH-bit operands on one 1-bit full-adder cell, LSB first.

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/serial_add_sequencer_if.sv | 40 ++++
 rtl/full_adder_cell.sv | 19 +
 rtl/serial_add_sequencer.sv | 122 ++++++++++++
 tb/tb_serial_add_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_add_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

  // Width of a counter that must be able to hold the value w itself.
  function automatic int idx_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Request/result bundle between the switch/KEY logic and the serial adder.
// Latency: n/a (wires only); ovf_o exists only with SERIAL_ADD_OVF_EN defined.
// Backpressure: start_i is dropped by the adder while busy_o is high.
interface serial_add_sequencer_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IDX_W = idx_width(WIDTH);

  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic [IDX_W-1:0] bit_idx_o;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_o;
`endif

  modport master (
    output start_i, a_i, b_i, cin_i,
    input  busy_o, done_o, sum_o, cout_o, bit_idx_o
`ifdef SERIAL_ADD_OVF_EN
    , ovf_o
`endif
  );

  modport slave (
    input  start_i, a_i, b_i, cin_i,
    output busy_o, done_o, sum_o, cout_o, bit_idx_o
`ifdef SERIAL_ADD_OVF_EN
    , ovf_o
`endif
  );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder shared by every bit position of the serial add.
// Latency: purely combinational.
// Backpressure: none.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half;

  // Classic propagate/generate form of the full adder.
  assign half = a ^ b;
  assign sum  = half ^ cin;
  assign cout = (a & b) | (cin & half);

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: LSB-first add of two WIDTH-bit operands on one full-adder cell.
// Latency: done_o is high in the cycle after accept edge + WIDTH edges; results held until next start.
// Backpressure: start_i ignored while busy_o; ovf_o added when SERIAL_ADD_OVF_EN is defined.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  rst,
  serial_add_sequencer_if.slave bus
);

  localparam int               IDX_W    = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] NUM_BITS = IDX_W'(WIDTH);

  sadd_state_t      state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  logic cell_a;
  logic cell_b;
  logic cell_sum;
  logic cell_cout;

  // Select the current operand bits; the counter parks at WIDTH after a run, so guard the range.
  always_comb begin
    cell_a = 1'b0;
    cell_b = 1'b0;
    if (bit_idx < NUM_BITS) begin
      cell_a = op_a[bit_idx];
      cell_b = op_b[bit_idx];
    end
  end

  full_adder_cell u_cell (
    .a    (cell_a),
    .b    (cell_b),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // Control FSM plus datapath registers; every output is a register.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      bit_idx <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (bus.start_i) begin
            op_a    <= bus.a_i;
            op_b    <= bus.b_i;
            carry   <= bus.cin_i;
            bit_idx <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[bit_idx] <= cell_sum;
          carry        <= cell_cout;
          bit_idx      <= bit_idx + IDX_W'(1);
          if (bit_idx == LAST_IDX) begin
            cout  <= cell_cout;
            // carry still holds the MSB carry-in on this edge.
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= carry ^ cell_cout;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.sum_o     = sum;
  assign bus.cout_o    = cout;
  assign bus.bit_idx_o = bit_idx;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf_o     = ovf;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed + random bench for serial_add_sequencer at WIDTH=5.
// Latency: expects done_o WIDTH edges after the accepting edge.
// Backpressure: covers ignored mid-run starts and back-to-back held start.
module tb_serial_add_sequencer;
  import serial_add_pkg::*;

  localparam int W = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_add_sequencer_if #(.WIDTH(W)) bus ();

  serial_add_sequencer #(.WIDTH(W)) dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic       cin;
    logic [4:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one add from IDLE and follow it through to the done pulse and one cycle after.
  task automatic do_op(input vec_t v, input string tag);
    int lat;
    int mask;
    @(negedge clk);
    bus.a_i     = v.a;
    bus.b_i     = v.b;
    bus.cin_i   = v.cin;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    lat = 0;
    while (!bus.done_o && lat < 20) begin
      if (lat < W) begin
        mask = (1 << lat) - 1;
        chk({tag, " busy"}, int'(bus.busy_o), 1);
        chk({tag, " bit_idx"}, int'(bus.bit_idx_o), lat);
        chk({tag, " partial"}, int'(bus.sum_o), int'(v.sum) & mask);
      end
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, W);
    chk({tag, " sum"}, int'(bus.sum_o), int'(v.sum));
    chk({tag, " cout"}, int'(bus.cout_o), int'(v.cout));
    chk({tag, " busy at done"}, int'(bus.busy_o), 0);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, " ovf"}, int'(bus.ovf_o), int'(v.ovf));
`endif
    tick();
    chk({tag, " done one-shot"}, int'(bus.done_o), 0);
    chk({tag, " sum held"}, int'(bus.sum_o), int'(v.sum));
  endtask

  initial begin
    int cnt;
    int ndone;
    logic [4:0] ca, cb, pa, pb;
    logic       cc, pc;
    logic [5:0] full;
    int         cmsb;

    checks = 0;
    errors = 0;

    //         a       b       cin   sum     cout  ovf
    vecs[0]  = '{5'h0B, 5'h06, 1'b0, 5'h11, 1'b0, 1'b1};
    vecs[1]  = '{5'h1F, 5'h01, 1'b0, 5'h00, 1'b1, 1'b0};
    vecs[2]  = '{5'h1F, 5'h01, 1'b1, 5'h01, 1'b1, 1'b0};
    vecs[3]  = '{5'h0F, 5'h01, 1'b0, 5'h10, 1'b0, 1'b1};
    vecs[4]  = '{5'h10, 5'h10, 1'b0, 5'h00, 1'b1, 1'b1};
    vecs[5]  = '{5'h03, 5'h04, 1'b0, 5'h07, 1'b0, 1'b0};
    vecs[6]  = '{5'h02, 5'h02, 1'b0, 5'h04, 1'b0, 1'b0};
    vecs[7]  = '{5'h00, 5'h00, 1'b1, 5'h01, 1'b0, 1'b0};
    vecs[8]  = '{5'h1F, 5'h1F, 1'b1, 5'h1F, 1'b1, 1'b0};
    vecs[9]  = '{5'h15, 5'h0A, 1'b0, 5'h1F, 1'b0, 1'b0};
    vecs[10] = '{5'h0A, 5'h0C, 1'b1, 5'h17, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.cin_i = 1'b0;
    tick();
    tick();
    chk("rst busy", int'(bus.busy_o), 0);
    chk("rst done", int'(bus.done_o), 0);
    chk("rst sum", int'(bus.sum_o), 0);
    chk("rst cout", int'(bus.cout_o), 0);
    chk("rst bit_idx", int'(bus.bit_idx_o), 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst ovf", int'(bus.ovf_o), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Start pulsed mid-run must be ignored
    @(negedge clk);
    bus.a_i = 5'h03; bus.b_i = 5'h04; bus.cin_i = 1'b0; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    bus.a_i = 5'h1F; bus.b_i = 5'h1F; bus.cin_i = 1'b1; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("ignore bit_idx", int'(bus.bit_idx_o), 3);
    cnt = 3;
    while (!bus.done_o && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("ignore latency", cnt, W);
    chk("ignore sum", int'(bus.sum_o), 32'h07);
    chk("ignore cout", int'(bus.cout_o), 0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done_o) ndone++;
    end
    chk("ignore no extra done", ndone, 0);
    chk("ignore idle busy", int'(bus.busy_o), 0);

    // Reset in the middle of a run, with start also high: reset wins
    @(negedge clk);
    bus.a_i = 5'h1F; bus.b_i = 5'h1F; bus.cin_i = 1'b1; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    chk("midrst bit_idx before", int'(bus.bit_idx_o), 2);
    rst = 1'b1;
    bus.start_i = 1'b1;
    tick();
    chk("midrst busy", int'(bus.busy_o), 0);
    chk("midrst done", int'(bus.done_o), 0);
    chk("midrst sum", int'(bus.sum_o), 0);
    chk("midrst cout", int'(bus.cout_o), 0);
    chk("midrst bit_idx", int'(bus.bit_idx_o), 0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done_o || bus.busy_o) ndone++;
    end
    chk("midrst stays idle", ndone, 0);
    do_op(vecs[6], "after rst");

    // Start held high, new operands each result: back-to-back ops against a+b+cin
    @(negedge clk);
    pa = 5'($urandom); pb = 5'($urandom); pc = 1'($urandom);
    bus.a_i = pa; bus.b_i = pb; bus.cin_i = pc; bus.start_i = 1'b1;
    tick();
    ca = pa; cb = pb; cc = pc;
    pa = 5'($urandom); pb = 5'($urandom); pc = 1'($urandom);
    bus.a_i = pa; bus.b_i = pb; bus.cin_i = pc;
    for (int n = 0; n < 1000; n++) begin
      cnt = 0;
      while (!bus.done_o && cnt < 20) begin
        tick();
        cnt++;
      end
      full = {1'b0, ca} + {1'b0, cb} + {5'b0, cc};
      chk("b2b period", cnt, W);
      chk("b2b result", int'({bus.cout_o, bus.sum_o}), int'(full));
`ifdef SERIAL_ADD_OVF_EN
      cmsb = ((int'(ca) & 15) + (int'(cb) & 15) + int'(cc)) >> 4;
      chk("b2b ovf", int'(bus.ovf_o), cmsb ^ int'(full[5]));
`else
      cmsb = 0;
`endif
      tick();
      chk("b2b accept busy", int'(bus.busy_o), 1);
      ca = pa; cb = pb; cc = pc;
      pa = 5'($urandom); pb = 5'($urandom); pc = 1'($urandom);
      bus.a_i = pa; bus.b_i = pb; bus.cin_i = pc;
    end
    bus.start_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
